// File: rtl/demux_2_lanes_c.sv
// Two-lane receive demultiplexer: splits an interleaved byte stream (slot 0 = lane 0,
// slot 1 = lane 1) into two registered lanes, published together once per slot pair.
module demux_2_lanes_c #(
   parameter int BUS_WIDTH = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] data_in,
   input  logic                 valid_in,
   output logic [BUS_WIDTH-1:0] data_out_0,
   output logic [BUS_WIDTH-1:0] data_out_1,
   output logic                 valid_out_0,
   output logic                 valid_out_1,
   output logic                 word_strobe,
   output logic                 slot,
   output logic [CNT_WIDTH-1:0] word_count
);

   logic                 r_slot;
   logic [BUS_WIDTH-1:0] r_cap0;
   logic                 r_cv0;
   logic [BUS_WIDTH-1:0] r_data0;
   logic [BUS_WIDTH-1:0] r_data1;
   logic                 r_valid0;
   logic                 r_valid1;
   logic                 r_strobe;
   logic [CNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot   <= 1'b0;
         r_cap0   <= '0;
         r_cv0    <= 1'b0;
         r_data0  <= '0;
         r_data1  <= '0;
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         r_strobe <= 1'b0;
         r_count  <= '0;
      end else begin
         r_slot <= ~r_slot;
         if (!r_slot) begin
            // Lane 0 is held back one slot so both lanes publish on the same edge.
            if (valid_in) begin
               r_cap0 <= data_in;
               r_cv0  <= 1'b1;
            end else begin
               r_cv0  <= 1'b0;
            end
            r_strobe <= 1'b0;
         end else begin
            r_valid0 <= r_cv0;
            if (r_cv0) r_data0 <= r_cap0;
            r_valid1 <= valid_in;
            if (valid_in) r_data1 <= data_in;
            r_strobe <= 1'b1;
            if (r_cv0 || valid_in) r_count <= r_count + 1'b1;
         end
      end
   end

   assign slot        = r_slot;
   assign data_out_0  = r_data0;
   assign data_out_1  = r_data1;
   assign valid_out_0 = r_valid0;
   assign valid_out_1 = r_valid1;
   assign word_strobe = r_strobe;
   assign word_count  = r_count;

endmodule

// File: tb/tb_demux_2_lanes_c.sv
// Directed, table-driven bench for demux_2_lanes_c with a hand-written counter-wrap sequence.
module tb_demux_2_lanes_c;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_out_0;
   logic [7:0] data_out_1;
   logic       valid_out_0;
   logic       valid_out_1;
   logic       word_strobe;
   logic       slot;
   logic [7:0] word_count;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      logic       rst;
      logic       vin;
      logic [7:0] din;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       v0;
      logic       v1;
      logic       stb;
      logic       sl;
      logic [7:0] cnt;
      string      name;
   } vec_t;

   vec_t vecs[$];

   demux_2_lanes_c #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .data_out_0  (data_out_0),
      .data_out_1  (data_out_1),
      .valid_out_0 (valid_out_0),
      .valid_out_1 (valid_out_1),
      .word_strobe (word_strobe),
      .slot        (slot),
      .word_count  (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic vin, input logic [7:0] din,
                      input logic [7:0] d0, input logic [7:0] d1, input logic v0,
                      input logic v1, input logic stb, input logic sl,
                      input logic [7:0] cnt, input string name);
      vec_t v;
      v.rst = rst; v.vin = vin; v.din = din; v.d0 = d0; v.d1 = d1;
      v.v0 = v0; v.v1 = v1; v.stb = stb; v.sl = sl; v.cnt = cnt; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got d0/d1/v0/v1/stb/slot/cnt=%h expected %h", name, act, exp);
   endtask

   function automatic logic [28:0] outs();
      return {data_out_0, data_out_1, valid_out_0, valid_out_1, word_strobe, slot, word_count};
   endfunction

   task automatic step(input logic rst, input logic vin, input logic [7:0] din);
      reset = rst; valid_in = vin; data_in = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;

      // 1: reset then idle
      add(1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "reset0");
      add(1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "reset1");
      for (int unsigned k = 1; k <= 8; k++)
         add(0, 0, 8'hAA, 8'h00, 8'h00, 0, 0, (k % 2) == 0, (k % 2) == 1, 8'd0, "idle");
      // 2: lane 0 only
      for (int unsigned p = 0; p < 4; p++) begin
         add(0, 1, 8'h13, (p == 0) ? 8'h00 : 8'h13, 8'h00, p != 0, 0, 0, 1, 8'(p), "l0_s0");
         add(0, 0, 8'hFD, 8'h13, 8'h00, 1, 0, 1, 0, 8'(p + 1), "l0_s1");
      end
      // 3: lane 1 only, then drop
      add(1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "reset_t3");
      for (int unsigned p = 0; p < 4; p++) begin
         add(0, 0, 8'h55, 8'h00, (p == 0) ? 8'h00 : 8'hF9, 0, p != 0, 0, 1, 8'(p), "l1_s0");
         add(0, 1, 8'hF9, 8'h00, 8'hF9, 0, 1, 1, 0, 8'(p + 1), "l1_s1");
      end
      for (int unsigned p = 0; p < 4; p++) begin
         add(0, 0, 8'hAA, 8'h00, 8'hF9, 0, p == 0, 0, 1, 8'd4, "drop_s0");
         add(0, 0, 8'hAA, 8'h00, 8'hF9, 0, 0, 1, 0, 8'd4, "drop_s1");
      end
      // 4: both lanes valid, changing data
      add(1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "reset_t4");
      add(0, 1, 8'h1B, 8'h00, 8'h00, 0, 0, 0, 1, 8'd0, "both0_s0");
      add(0, 1, 8'hF5, 8'h1B, 8'hF5, 1, 1, 1, 0, 8'd1, "both0_s1");
      add(0, 1, 8'h1C, 8'h1B, 8'hF5, 1, 1, 0, 1, 8'd1, "both1_s0");
      add(0, 1, 8'hF4, 8'h1C, 8'hF4, 1, 1, 1, 0, 8'd2, "both1_s1");
      add(0, 1, 8'h1D, 8'h1C, 8'hF4, 1, 1, 0, 1, 8'd2, "both2_s0");
      add(0, 1, 8'hF3, 8'h1D, 8'hF3, 1, 1, 1, 0, 8'd3, "both2_s1");
      add(0, 0, 8'hAA, 8'h1D, 8'hF3, 1, 1, 0, 1, 8'd3, "both_hold");
      // 5: reset mid-word discards the captured lane-0 byte
      add(1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "reset_t5");
      add(0, 1, 8'h20, 8'h00, 8'h00, 0, 0, 0, 1, 8'd0, "mid_s0");
      add(1, 1, 8'h77, 8'h00, 8'h00, 0, 0, 0, 0, 8'd0, "mid_reset");
      add(0, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 1, 8'd0, "mid_after_s0");
      add(0, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 1, 0, 8'd0, "mid_after_s1");

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].vin, vecs[i].din);
         check(vecs[i].name, outs(),
               {vecs[i].d0, vecs[i].d1, vecs[i].v0, vecs[i].v1, vecs[i].stb, vecs[i].sl, vecs[i].cnt});
      end

      // 6: counter wrap after 257 lane-0 words
      step(1, 0, 8'h00);
      for (int unsigned i = 0; i < 257; i++) begin
         step(0, 1, 8'(i + 8'h40));
         step(0, 0, 8'hAA);
         if (i == 255)
            check("wrap_256", outs(), {8'h3F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      end
      check("wrap_257", outs(), {8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
